// File: rtl/uart_router_pkg.sv
// Shared constants and state encodings for the UART <-> SerialTL byte router.
package uart_router_pkg;

    localparam logic [7:0] STL_HDR = 8'h53;
    localparam logic [7:0] CFG_HDR = 8'h43;

    localparam int DEF_STL_BYTES      = 16;
    localparam int DEF_CFG_BYTES      = 8;
    localparam int DEF_RESP_BYTES     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_FWD_STL = 2'd1,
        RX_FWD_CFG = 2'd2,
        RX_PAD     = 2'd3
    } rx_state_e;

    typedef enum logic {
        TX_HDR  = 1'b0,
        TX_BODY = 1'b1
    } tx_state_e;

endpackage

// File: rtl/uart_tx_framer.sv
// Prefixes every RESP_BYTES-long STL response with a single header byte on the UART TX stream.
module uart_tx_framer #(
    parameter int         RESP_BYTES = uart_router_pkg::DEF_RESP_BYTES,
    parameter logic [7:0] HDR_BYTE   = uart_router_pkg::STL_HDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stl_resp_valid,
    output logic       stl_resp_ready,
    input  logic [7:0] stl_resp_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data
);
    import uart_router_pkg::*;

    localparam int CNT_W = $clog2(RESP_BYTES + 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_HDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_xfer = tx_valid && tx_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            TX_HDR: begin
                if (tx_xfer) begin
                    state_d = TX_BODY;
                    cnt_d   = '0;
                end
            end
            TX_BODY: begin
                if (tx_xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(RESP_BYTES - 1)) begin
                        state_d = TX_HDR;
                    end
                end
            end
            default: state_d = TX_HDR;
        endcase
    end

    // The header byte only appears on the bus once a response is pending, so an idle TX reads 0.
    always_comb begin
        tx_valid       = stl_resp_valid;
        tx_data        = 8'h00;
        stl_resp_ready = 1'b0;
        case (state_q)
            TX_HDR: begin
                tx_data = stl_resp_valid ? HDR_BYTE : 8'h00;
            end
            TX_BODY: begin
                tx_data        = stl_resp_data;
                stl_resp_ready = tx_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/uart_stl_router.sv
// Routes header-tagged UART RX frames to the STL or config byte stream, zero-padding
// frames cut short by an inter-byte timeout, and frames STL responses onto UART TX.
module uart_stl_router #(
    parameter int         STL_BYTES      = uart_router_pkg::DEF_STL_BYTES,
    parameter int         CFG_BYTES      = uart_router_pkg::DEF_CFG_BYTES,
    parameter int         RESP_BYTES     = uart_router_pkg::DEF_RESP_BYTES,
    parameter logic [7:0] STL_HDR        = uart_router_pkg::STL_HDR,
    parameter logic [7:0] CFG_HDR        = uart_router_pkg::CFG_HDR,
    parameter int         TIMEOUT_CYCLES = uart_router_pkg::DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       stl_valid,
    input  logic       stl_ready,
    output logic [7:0] stl_data,
    output logic       cfg_valid,
    input  logic       cfg_ready,
    output logic [7:0] cfg_data,
    input  logic       stl_resp_valid,
    output logic       stl_resp_ready,
    input  logic [7:0] stl_resp_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic [7:0] bad_hdr_count,
    output logic [7:0] timeout_count,
    output logic [1:0] rx_state
);
    import uart_router_pkg::*;

    localparam int MAX_BYTES = (STL_BYTES > CFG_BYTES) ? STL_BYTES : CFG_BYTES;
    localparam int REM_W     = $clog2(MAX_BYTES + 1);
    localparam int TMR_W     = $clog2(TIMEOUT_CYCLES + 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    rx_state_e        state_q, state_d;
    logic [REM_W-1:0] remaining_q, remaining_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             dest_stl_q, dest_stl_d;
    logic [7:0]       bad_q, bad_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            remaining_q <= '0;
            timer_q     <= '0;
            dest_stl_q  <= 1'b0;
            bad_q       <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            dest_stl_q  <= dest_stl_d;
            bad_q       <= bad_d;
            tmo_q       <= tmo_d;
        end
    end

    assign xfer = (stl_valid && stl_ready) || (cfg_valid && cfg_ready);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        dest_stl_d  = dest_stl_q;
        bad_d       = bad_q;
        tmo_d       = tmo_q;
        case (state_q)
            RX_IDLE: begin
                if (rx_valid) begin
                    timer_d = '0;
                    if (rx_data == STL_HDR) begin
                        state_d     = RX_FWD_STL;
                        remaining_d = REM_W'(STL_BYTES);
                        dest_stl_d  = 1'b1;
                    end else if (rx_data == CFG_HDR) begin
                        state_d     = RX_FWD_CFG;
                        remaining_d = REM_W'(CFG_BYTES);
                        dest_stl_d  = 1'b0;
                    end else begin
                        bad_d = sat_inc(bad_q);
                    end
                end
            end
            RX_FWD_STL, RX_FWD_CFG: begin
                // A transfer wins over an expiring timer; backpressure (rx_valid held) never ages it.
                if (xfer) begin
                    remaining_d = remaining_q - REM_W'(1);
                    timer_d     = '0;
                    if (remaining_q == REM_W'(1)) begin
                        state_d = RX_IDLE;
                    end
                end else if (!rx_valid) begin
                    if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = RX_PAD;
                        tmo_d   = sat_inc(tmo_q);
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            RX_PAD: begin
                if (xfer) begin
                    remaining_d = remaining_q - REM_W'(1);
                    if (remaining_q == REM_W'(1)) begin
                        state_d = RX_IDLE;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = 1'b0;
        stl_valid = 1'b0;
        stl_data  = 8'h00;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        case (state_q)
            RX_IDLE: rx_ready = 1'b1;
            RX_FWD_STL: begin
                stl_valid = rx_valid;
                stl_data  = rx_data;
                rx_ready  = stl_ready;
            end
            RX_FWD_CFG: begin
                cfg_valid = rx_valid;
                cfg_data  = rx_data;
                rx_ready  = cfg_ready;
            end
            RX_PAD: begin
                stl_valid = dest_stl_q;
                cfg_valid = !dest_stl_q;
            end
            default: ;
        endcase
    end

    assign rx_state      = state_q;
    assign bad_hdr_count = bad_q;
    assign timeout_count = tmo_q;

    uart_tx_framer #(
        .RESP_BYTES(RESP_BYTES),
        .HDR_BYTE  (STL_HDR)
    ) u_tx_framer (
        .clk           (clk),
        .reset         (reset),
        .stl_resp_valid(stl_resp_valid),
        .stl_resp_ready(stl_resp_ready),
        .stl_resp_data (stl_resp_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data)
    );

endmodule

// File: tb/tb_uart_stl_router.sv
// Directed bench for uart_stl_router: routing, bad headers, timeout padding, TX framing, mid-frame reset.
module tb_uart_stl_router;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid, rx_ready;
    logic [7:0] rx_data;
    logic       stl_valid, stl_ready;
    logic [7:0] stl_data;
    logic       cfg_valid, cfg_ready;
    logic [7:0] cfg_data;
    logic       stl_resp_valid, stl_resp_ready;
    logic [7:0] stl_resp_data;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic [7:0] bad_hdr_count, timeout_count;
    logic [1:0] rx_state;

    always #5 clk = ~clk;

    uart_stl_router #(
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .stl_valid     (stl_valid),
        .stl_ready     (stl_ready),
        .stl_data      (stl_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_data      (cfg_data),
        .stl_resp_valid(stl_resp_valid),
        .stl_resp_ready(stl_resp_ready),
        .stl_resp_data (stl_resp_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .bad_hdr_count (bad_hdr_count),
        .timeout_count (timeout_count),
        .rx_state      (rx_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] stl_q[$];
    logic [7:0] cfg_q[$];
    logic [7:0] tx_q[$];
    int  stl_vld_n = 0;
    int  cfg_vld_n = 0;
    int  pad_rdy_n = 0;
    logic cfg_toggle = 1'b0;
    logic tx_rand    = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (stl_valid && stl_ready) stl_q.push_back(stl_data);
            if (cfg_valid && cfg_ready) cfg_q.push_back(cfg_data);
            if (tx_valid && tx_ready)   tx_q.push_back(tx_data);
            if (stl_valid) stl_vld_n++;
            if (cfg_valid) cfg_vld_n++;
            if (rx_state == 2'd3 && rx_ready) pad_rdy_n++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (cfg_toggle) cfg_ready = ~cfg_ready;
        if (tx_rand)    tx_ready  = 1'($urandom_range(0, 1));
    end

    task automatic clear_mon();
        stl_q.delete();
        cfg_q.delete();
        tx_q.delete();
        stl_vld_n = 0;
        cfg_vld_n = 0;
        pad_rdy_n = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        rx_valid = 1'b0;
        if (!ok) chk("rx_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_resp(input logic [7:0] b);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        stl_resp_valid = 1'b1;
        stl_resp_data  = b;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok = stl_resp_ready;
            @(posedge clk);
            #1;
            n++;
        end
        stl_resp_valid = 1'b0;
        if (!ok) chk("resp_accept", 32'(ok), 32'd1);
    endtask

    task automatic cmp_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    task automatic stl_frame(input logic [7:0] base, input string tag);
        logic [7:0] exp[$];
        clear_mon();
        send_byte(8'h53);
        for (int i = 0; i < 16; i++) begin
            send_byte(base + 8'(i));
            exp.push_back(base + 8'(i));
        end
        chk({tag, "_state_after"}, 32'(rx_state), 32'd0);
        cmp_q({tag, "_stl"}, stl_q, exp);
        chk({tag, "_no_cfg"}, 32'(cfg_vld_n), 32'd0);
    endtask

    initial begin
        logic [7:0] exp[$];
        int n;
        reset          = 1'b1;
        rx_valid       = 1'b0;
        rx_data        = 8'h00;
        stl_ready      = 1'b1;
        cfg_ready      = 1'b1;
        stl_resp_valid = 1'b0;
        stl_resp_data  = 8'h00;
        tx_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_state", 32'(rx_state), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_stl_valid", 32'(stl_valid), 32'd0);
        chk("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_resp_ready", 32'(stl_resp_ready), 32'd0);
        chk("rst_data", {8'h00, stl_data, cfg_data, tx_data}, 32'd0);
        chk("rst_counts", {16'h0, bad_hdr_count, timeout_count}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full STL frame, checking the state just before and after the last byte.
        clear_mon();
        send_byte(8'h53);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("stl_state_mid", 32'(rx_state), 32'd1);
            send_byte(8'(i));
        end
        chk("stl_state_after", 32'(rx_state), 32'd0);
        exp.delete();
        for (int i = 0; i < 16; i++) exp.push_back(8'(i));
        cmp_q("stl1", stl_q, exp);
        chk("stl1_no_cfg", 32'(cfg_vld_n), 32'd0);

        // Config frame under toggling backpressure.
        clear_mon();
        cfg_toggle = 1'b1;
        send_byte(8'h43);
        for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
        cfg_toggle = 1'b0;
        cfg_ready  = 1'b1;
        chk("cfg_state_after", 32'(rx_state), 32'd0);
        exp.delete();
        for (int i = 0; i < 8; i++) exp.push_back(8'hA0 + 8'(i));
        cmp_q("cfg1", cfg_q, exp);
        chk("cfg1_no_stl", 32'(stl_vld_n), 32'd0);
        chk("cfg1_no_timeout", 32'(timeout_count), 32'd0);

        // Unknown header dropped, then a normal frame.
        send_byte(8'h7E);
        chk("bad_hdr_count", 32'(bad_hdr_count), 32'd1);
        chk("bad_hdr_state", 32'(rx_state), 32'd0);
        stl_frame(8'h60, "stl2");

        // Partial frame, timeout, zero padding.
        clear_mon();
        send_byte(8'h53);
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
        n = 0;
        while (rx_state != 2'd3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_enter_pad", 32'(rx_state), 32'd3);
        chk("tmo_latency", 32'(n), 32'd101);
        chk("pad_rx_ready", 32'(rx_ready), 32'd0);
        n = 0;
        while (rx_state != 2'd0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pad_exit", 32'(rx_state), 32'd0);
        exp.delete();
        for (int i = 0; i < 5; i++) exp.push_back(8'h30 + 8'(i));
        for (int i = 0; i < 11; i++) exp.push_back(8'h00);
        cmp_q("pad", stl_q, exp);
        chk("pad_no_cfg", 32'(cfg_vld_n), 32'd0);
        chk("pad_rdy_low", 32'(pad_rdy_n), 32'd0);
        chk("timeout_count", 32'(timeout_count), 32'd1);
        @(posedge clk);
        #1;
        clear_mon();
        send_byte(8'h43);
        for (int i = 0; i < 8; i++) send_byte(8'hB0 + 8'(i));
        exp.delete();
        for (int i = 0; i < 8; i++) exp.push_back(8'hB0 + 8'(i));
        cmp_q("post_tmo_cfg", cfg_q, exp);

        // TX framing under random tx_ready.
        clear_mon();
        tx_rand = 1'b1;
        for (int i = 0; i < 32; i++) send_resp(8'h10 + 8'(i));
        tx_rand = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        exp.delete();
        exp.push_back(8'h53);
        for (int i = 0; i < 16; i++) exp.push_back(8'h10 + 8'(i));
        exp.push_back(8'h53);
        for (int i = 0; i < 16; i++) exp.push_back(8'h20 + 8'(i));
        cmp_q("tx", tx_q, exp);

        // Reset in the middle of an STL payload.
        send_byte(8'h53);
        for (int i = 0; i < 7; i++) send_byte(8'h70 + 8'(i));
        chk("pre_rst_state", 32'(rx_state), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_state", 32'(rx_state), 32'd0);
        chk("mid_rst_valids", {29'h0, stl_valid, cfg_valid, tx_valid}, 32'd0);
        chk("mid_rst_counts", {16'h0, bad_hdr_count, timeout_count}, 32'd0);
        chk("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
        stl_frame(8'h80, "stl3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_stl_router.md
Name: uart_stl_router

Overview:
- Byte-level framing and routing stage between the UART RX/TX byte FIFOs and the SerialTL subsystem's byte interfaces.
- On receive, a one-byte header selects the destination: the STL subsystem or the configuration/scan-chain subsystem. The router then forwards a fixed-length payload to that destination.
- Partial frames are zero-padded on inter-byte timeout, so downstream packet assemblers stay aligned.
- On transmit, each fixed-length STL response is prefixed with a header byte.

Parameters:
- STL_BYTES, 16, payload bytes per STL request frame.
- CFG_BYTES, 8, payload bytes per config frame.
- RESP_BYTES, 16, STL response bytes per TX frame.
- STL_HDR, 8'h53, header byte selecting STL.
- CFG_HDR, 8'h43, header byte selecting config.
- TIMEOUT_CYCLES, 1_000_000, idle cycles mid-payload before abort (10 ms at 100 MHz).

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high.
- rx_valid  in  1  / rx_ready  out  1  / rx_data  in  8  : byte stream from UART RX.
- stl_valid  out  1  / stl_ready  in  1  / stl_data  out  8  : to serialtl_subsystem data_in.
- cfg_valid  out  1  / cfg_ready  in  1  / cfg_data  out  8  : to config subsystem.
- stl_resp_valid  in  1  / stl_resp_ready  out  1  / stl_resp_data  in  8  : from serialtl_subsystem response.
- tx_valid  out  1  / tx_ready  in  1  / tx_data  out  8  : to UART TX.
- bad_hdr_count  out  8  : saturating count of unknown headers.
- timeout_count  out  8  : saturating count of timeouts.
- rx_state  out  2  : debug encoding of the RX FSM.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, and sampled only at the rising edge of clk.
- Reset values:
  - RX FSM in IDLE; TX FSM in HDR.
  - All counters 0.
  - stl_valid, cfg_valid, tx_valid, stl_resp_ready all 0.
  - rx_ready 1 (IDLE).
  - stl_data, cfg_data, tx_data 0.
  - rx_state 2'd0.
- Handshakes: a transfer occurs on valid&&ready at the clock edge. Valid never depends combinationally on ready of the same interface.
- RX FSM states, with rx_state encoding: IDLE=0, FWD_STL=1, FWD_CFG=2, PAD=3.
- IDLE:
  - rx_ready=1; no downstream valid.
  - On accepting a byte:
    - ==STL_HDR -> FWD_STL, remaining=STL_BYTES.
    - ==CFG_HDR -> FWD_CFG, remaining=CFG_BYTES.
    - Otherwise the byte is dropped, bad_hdr_count increments (saturating at 255), and the FSM stays in IDLE.
- FWD_x (zero-latency combinational pass-through):
  - x_valid=rx_valid, x_data=rx_data, rx_ready=x_ready.
  - On each transfer: remaining decrements and the idle timer clears.
  - When the last byte transfers (remaining==1), the FSM returns to IDLE on the next cycle.
- Idle timer:
  - Increments only when rx_valid=0 in a FWD state. Downstream backpressure (rx_valid=1, x_ready=0) never counts toward timeout.
  - When the timer reaches TIMEOUT_CYCLES-1 without a transfer: go to PAD, timeout_count increments (saturating), and the timer clears.
- PAD:
  - rx_ready=0; the selected x_valid=1 with x_data=8'h00.
  - remaining decrements per transfer; IDLE after the last pad byte.
  - A destination register records STL vs CFG for PAD.
- Simultaneous events: a byte accepted in the same cycle the timer would expire counts as a transfer, with no timeout.
- Counter widths: remaining and the idle timer are sized with $clog2 of their maxima (+1).
- TX FSM states: HDR, BODY.
  - HDR: tx_valid=stl_resp_valid, tx_data=STL_HDR, stl_resp_ready=0. On tx transfer -> BODY, body count=0.
  - BODY: tx_valid=stl_resp_valid, tx_data=stl_resp_data, stl_resp_ready=tx_ready. On the RESP_BYTES-th transfer -> HDR.
- RX and TX FSMs are fully independent; concurrent activity is legal.
- Reset mid-frame: both FSMs return to reset state immediately. No padding is emitted, and any partial downstream frame is the downstream block's responsibility; system reset covers both.

Decomposition:
- Shared package (uart_router_pkg):
  - Header constants STL_HDR and CFG_HDR.
  - RX state encoding, used by rx_state debug decoding.
  - Default frame lengths.
- Natural sub-module: uart_tx_framer (TX HDR/BODY FSM, approx. 50 lines). RX routing and padding stay in the top.

Test Plan:
- Send 0x53 then 16 bytes 0x00..0x0F with stl_ready=1 -> stl_data sees exactly 0x00..0x0F; rx_state returns to 0 one cycle after the last byte; cfg_valid never asserts.
- Send 0x43 then 8 bytes 0xA0..0xA7 while cfg_ready toggles every other cycle -> all 8 bytes delivered in order; no stl_valid; timeout_count stays 0 despite stalls.
- Send 0x7E, then 0x53 plus 16 bytes -> 0x7E dropped, bad_hdr_count=1, STL frame delivered intact.
- Send 0x53 plus 5 bytes, then idle TIMEOUT_CYCLES (TIMEOUT_CYCLES=100 in bench) -> rx_state=3; 11 bytes of 0x00 emitted on stl_data; rx_ready=0 during PAD; timeout_count=1; next header accepted normally.
- STL response of 32 bytes 0x10..0x2F with tx_ready random -> tx stream is 0x53, 0x10..0x1F, 0x53, 0x20..0x2F.
- Assert reset for 1 cycle mid-payload (after 7 of 16 STL bytes) -> next cycle rx_state=0, all valids 0, counters 0; a subsequent full frame routes correctly.
